// File: rtl/pong_game_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pong_game_ctrl_if                                                        |
// | Player/frame inputs and renderer-facing game state of the pong core.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface pong_game_ctrl_if;
  logic       iFrame;
  logic       iStart;
  logic       iP1_up;
  logic       iP1_dn;
  logic       iP2_up;
  logic       iP2_dn;
  logic [9:0] oBallX;
  logic [9:0] oBallY;
  logic [9:0] oPad1Y;
  logic [9:0] oPad2Y;
  logic [3:0] oScore1;
  logic [3:0] oScore2;
  logic [1:0] oState;
  logic [1:0] oWinner;
  logic       oScoreEvt;

  modport master (
    output iFrame, iStart, iP1_up, iP1_dn, iP2_up, iP2_dn,
    input  oBallX, oBallY, oPad1Y, oPad2Y, oScore1, oScore2, oState, oWinner, oScoreEvt
  );

  modport slave (
    input  iFrame, iStart, iP1_up, iP1_dn, iP2_up, iP2_dn,
    output oBallX, oBallY, oPad1Y, oPad2Y, oScore1, oScore2, oState, oWinner, oScoreEvt
  );
endinterface
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pong_game_ctrl                                                           |
// | Frame-synchronous pong state: paddles, ball, bounces, scoring, serve.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pong_game_ctrl #(
  parameter int SCR_W        = 640,
  parameter int SCR_H        = 480,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 64,
  parameter int PAD1_X       = 16,
  parameter int PAD2_X       = 616,
  parameter int BALL_SZ      = 8,
  parameter int PAD_SPD      = 4,
  parameter int BALL_SPD     = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  wire logic       iclk,
  input  wire logic       irst_n,
  pong_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SERVE    = 2'd1,
    S_PLAY     = 2'd2,
    S_GAMEOVER = 2'd3
  } state_t;

  localparam logic [9:0]  c_ball_x0   = 10'((SCR_W - BALL_SZ) / 2);
  localparam logic [9:0]  c_ball_y0   = 10'((SCR_H - BALL_SZ) / 2);
  localparam logic [9:0]  c_pad_y0    = 10'((SCR_H - PAD_H) / 2);
  localparam logic [10:0] c_pad_ymax  = 11'(SCR_H - PAD_H);
  localparam logic [10:0] c_ball_xmax = 11'(SCR_W - BALL_SZ);
  localparam logic [10:0] c_ball_ymax = 11'(SCR_H - BALL_SZ);
  localparam logic [10:0] c_l_face    = 11'(PAD1_X + PAD_W);
  localparam logic [10:0] c_r_face    = 11'(PAD2_X);
  localparam logic [10:0] c_r_stop    = 11'(PAD2_X - BALL_SZ);
  localparam logic [10:0] c_pad_spd   = 11'(PAD_SPD);
  localparam logic [10:0] c_ball_spd  = 11'(BALL_SPD);
  localparam logic [10:0] c_ball_sz   = 11'(BALL_SZ);
  localparam logic [10:0] c_pad_h     = 11'(PAD_H);
  localparam logic [3:0]  c_win       = 4'(WIN_SCORE);
  localparam int          c_cnt_w     = $clog2(SERVE_FRAMES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SERVE_FRAMES - 1);

  state_t             r_state, w_state;
  logic [9:0]         r_ball_x, w_ball_x;
  logic [9:0]         r_ball_y, w_ball_y;
  logic [9:0]         r_pad1, w_pad1;
  logic [9:0]         r_pad2, w_pad2;
  logic [3:0]         r_score1, w_score1;
  logic [3:0]         r_score2, w_score2;
  logic [1:0]         r_winner, w_winner;
  logic               r_evt, w_evt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt;
  logic               r_dx, w_dx;
  logic               r_dy, w_dy;

  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
    logic [10:0] t;
    t = {1'b0, y};
    if (up && !dn)
      t = (t <= c_pad_spd) ? 11'd0 : t - c_pad_spd;
    else if (dn && !up)
      t = (t + c_pad_spd >= c_pad_ymax) ? c_pad_ymax : t + c_pad_spd;
    return 10'(t);
  endfunction

  logic [9:0]  w_pad1_step, w_pad2_step;
  logic [10:0] w_bx, w_by, w_p1, w_p2;
  logic        w_ov1, w_ov2, w_hit_l, w_hit_r, w_miss_l, w_miss_r;
  logic [9:0]  w_x_mov, w_y_mov;
  logic        w_dx_mov, w_dy_mov;

  assign w_pad1_step = pad_step(r_pad1, bus.iP1_up, bus.iP1_dn);
  assign w_pad2_step = pad_step(r_pad2, bus.iP2_up, bus.iP2_dn);

  assign w_bx = {1'b0, r_ball_x};
  assign w_by = {1'b0, r_ball_y};
  assign w_p1 = {1'b0, r_pad1};
  assign w_p2 = {1'b0, r_pad2};

  // Collision tests deliberately use the paddle positions from before this frame's move.
  assign w_ov1    = (w_by + c_ball_sz > w_p1) && (w_by < w_p1 + c_pad_h);
  assign w_ov2    = (w_by + c_ball_sz > w_p2) && (w_by < w_p2 + c_pad_h);
  assign w_hit_l  = !r_dx && (w_bx >= c_l_face) && (w_bx <= c_l_face + c_ball_spd) && w_ov1;
  assign w_hit_r  = r_dx && (w_bx + c_ball_sz <= c_r_face)
                  && (w_bx + c_ball_sz + c_ball_spd >= c_r_face) && w_ov2;
  assign w_miss_l = !r_dx && (w_bx <= c_ball_spd) && !w_hit_l;
  assign w_miss_r = r_dx && (w_bx + c_ball_spd >= c_ball_xmax) && !w_hit_r;

  always_comb begin
    w_y_mov  = r_ball_y;
    w_dy_mov = r_dy;
    if (!r_dy) begin
      if (w_by <= c_ball_spd) begin
        w_y_mov  = 10'd0;
        w_dy_mov = 1'b1;
      end else begin
        w_y_mov  = 10'(w_by - c_ball_spd);
      end
    end else if (w_by + c_ball_spd >= c_ball_ymax) begin
      w_y_mov  = 10'(c_ball_ymax);
      w_dy_mov = 1'b0;
    end else begin
      w_y_mov  = 10'(w_by + c_ball_spd);
    end

    w_x_mov  = r_ball_x;
    w_dx_mov = r_dx;
    if (w_hit_l) begin
      w_x_mov  = 10'(c_l_face);
      w_dx_mov = 1'b1;
    end else if (w_hit_r) begin
      w_x_mov  = 10'(c_r_stop);
      w_dx_mov = 1'b0;
    end else if (r_dx) begin
      w_x_mov  = 10'(w_bx + c_ball_spd);
    end else if (w_bx <= c_ball_spd) begin
      w_x_mov  = 10'd0;
    end else begin
      w_x_mov  = 10'(w_bx - c_ball_spd);
    end
  end

  always_comb begin
    w_state  = r_state;
    w_ball_x = r_ball_x;
    w_ball_y = r_ball_y;
    w_pad1   = r_pad1;
    w_pad2   = r_pad2;
    w_score1 = r_score1;
    w_score2 = r_score2;
    w_winner = r_winner;
    w_evt    = 1'b0;
    w_cnt    = r_cnt;
    w_dx     = r_dx;
    w_dy     = r_dy;
    case (r_state)
      S_IDLE, S_GAMEOVER: begin
        // A start request takes priority over a coincident frame pulse.
        if (bus.iStart) begin
          w_state  = S_SERVE;
          w_score1 = 4'd0;
          w_score2 = 4'd0;
          w_winner = 2'd0;
          w_cnt    = '0;
          w_dx     = 1'b1;
          w_ball_x = c_ball_x0;
          w_ball_y = c_ball_y0;
        end
      end
      S_SERVE: begin
        if (bus.iFrame) begin
          w_pad1   = w_pad1_step;
          w_pad2   = w_pad2_step;
          w_ball_x = c_ball_x0;
          w_ball_y = c_ball_y0;
          if (r_cnt == c_cnt_last) begin
            w_state = S_PLAY;
            w_cnt   = '0;
          end else begin
            w_cnt   = r_cnt + 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (bus.iFrame) begin
          w_pad1   = w_pad1_step;
          w_pad2   = w_pad2_step;
          w_ball_x = w_x_mov;
          w_ball_y = w_y_mov;
          w_dx     = w_dx_mov;
          w_dy     = w_dy_mov;
          if (w_miss_l || w_miss_r) begin
            w_evt    = 1'b1;
            w_ball_x = c_ball_x0;
            w_ball_y = c_ball_y0;
            w_dx     = w_miss_r;
            w_dy     = ~r_dy;
            w_cnt    = '0;
            w_state  = S_SERVE;
            if (w_miss_l) begin
              if (r_score2 < c_win) w_score2 = r_score2 + 4'd1;
              if (r_score2 >= c_win - 4'd1) begin
                w_state  = S_GAMEOVER;
                w_winner = 2'd2;
              end
            end else begin
              if (r_score1 < c_win) w_score1 = r_score1 + 4'd1;
              if (r_score1 >= c_win - 4'd1) begin
                w_state  = S_GAMEOVER;
                w_winner = 2'd1;
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      r_state  <= S_IDLE;
      r_ball_x <= c_ball_x0;
      r_ball_y <= c_ball_y0;
      r_pad1   <= c_pad_y0;
      r_pad2   <= c_pad_y0;
      r_score1 <= 4'd0;
      r_score2 <= 4'd0;
      r_winner <= 2'd0;
      r_evt    <= 1'b0;
      r_cnt    <= '0;
      r_dx     <= 1'b1;
      r_dy     <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_ball_x <= w_ball_x;
      r_ball_y <= w_ball_y;
      r_pad1   <= w_pad1;
      r_pad2   <= w_pad2;
      r_score1 <= w_score1;
      r_score2 <= w_score2;
      r_winner <= w_winner;
      r_evt    <= w_evt;
      r_cnt    <= w_cnt;
      r_dx     <= w_dx;
      r_dy     <= w_dy;
    end
  end

  assign bus.oBallX    = r_ball_x;
  assign bus.oBallY    = r_ball_y;
  assign bus.oPad1Y    = r_pad1;
  assign bus.oPad2Y    = r_pad2;
  assign bus.oScore1   = r_score1;
  assign bus.oScore2   = r_score2;
  assign bus.oState    = r_state;
  assign bus.oWinner   = r_winner;
  assign bus.oScoreEvt = r_evt;

endmodule
`default_nettype wire
